sklansky_pipe_subtractor: RTL and testbench
===========================================

Name: sklansky_pipe_subtractor

Overview:
Pipelined two's-complement subtractor computing a - b with a Sklansky parallel-prefix borrow network. One pipeline register follows each prefix level. It is the inverse-operation counterpart of the combinational prefix adders in the math/add library. Operands enter on a valid/ready handshake. The difference and comparison flags leave on a second valid/ready handshake. It serves as the compare/subtract unit for datapaths that need full throughput at high clock rates.

Parameters:
WIDTH, 32, operand width; power of two, >= 2
TAG_W, 4, width of the opaque sideband tag carried alongside each operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
in_tag  input  TAG_W  sideband, returned unchanged with the result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b mod 2^WIDTH
borrow  output  1  1 when a < b unsigned (inverted carry-out)
overflow  output  1  signed overflow of a - b
zero  output  1  diff == 0
lt_s  output  1  a < b signed
out_tag  output  TAG_W  in_tag of this result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. When rst_n is low at a clock edge, every stage valid bit clears, every data register clears to 0, and out_valid, diff, borrow, overflow, zero, lt_s and out_tag are all 0.
- Stages, with N = $clog2(WIDTH):
  - S0, PG generation: p_i = a_i ^ ~b_i and g_i = a_i & ~b_i. Carry-in is 1, folded into bit 0 as g_0' = g_0 | p_0, p_0' = 0. The original p vector and tag are registered alongside.
  - S1..SN: one Sklansky level per stage. At level k, bits in the upper half of each 2^k block combine with the top bit of the lower half via blackcell (G = g_hi | p_hi&g_lo, P = p_hi&p_lo). Lower-half bits pass through.
  - SN+1, sum/flags:
    - diff_i = p_i ^ G[i-1:0]; diff_0 = p_0 ^ 1.
    - borrow = ~G[WIDTH-1:0].
    - overflow = (a_msb != b_msb) && (diff_msb != a_msb); a_msb and b_msb are carried through the pipeline.
    - lt_s = diff_msb ^ overflow.
    - zero = ~|diff.
    - All are registered into the output.
- Latency: N+2 cycles from the in_valid&&in_ready edge to out_valid. WIDTH=8 gives 5; WIDTH=32 gives 7.
- Throughput: one operation per cycle when out_ready is held high.
- Flow control uses a global enable: en = !out_valid || out_ready, and in_ready = en.
  - When en=0, every stage register, including valid bits and data, holds.
  - Bubbles inside the pipe do not collapse during a stall. This is accepted behaviour.
- Input acceptance: an operand pair is taken only on in_valid && in_ready. If in_valid=0 while en=1, a bubble (valid=0) is inserted.
- Output stability: while out_valid=1 and out_ready=0, diff, all flags and out_tag stay stable. No result is dropped, duplicated or reordered.
- Simultaneous output and input: when out_valid && out_ready is concurrent with in_valid, the result retires and the pipe advances in the same cycle.
- Reset mid-operation flushes every in-flight operation. None of them emerge after reset deasserts.
- Edge cases:
  - a == b gives zero=1 and borrow=0.
  - WIDTH=2 gives N=1, with a single prefix stage.

Decomposition:
- Package prefix_pkg:
  - function prefix_levels(width), returning $clog2;
  - typedef pg_t holding the g and p bit pair;
  - localparam for the folded carry-in constant (1 for subtract).
- Sub-module sklansky_pipe_level #(WIDTH, LEVEL):
  - combinational level-k blackcell network, built from the existing blackcell;
  - followed by the stage register with en, valid and a sideband passthrough;
  - instantiated N times in a generate loop.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, tag=1 -> after 5 cycles: diff=8'h02, borrow=0, overflow=0, zero=0, lt_s=0, out_tag=1.
- WIDTH=8, a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1, lt_s=1, overflow=0, zero=0.
- WIDTH=8, a=8'h80, b=8'h01 -> diff=8'h7F, overflow=1, lt_s=1, borrow=0. Then a=8'h5A, b=8'h5A -> diff=0, zero=1, borrow=0.
- WIDTH=32, 1000 random pairs back-to-back with out_ready=1 -> one result per cycle after 7 cycles of latency; every field matches the reference model; tags arrive in order.
- Backpressure: stream tags 0..9 and drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 for those cycles; output fields stay stable; all 10 results arrive in order with no duplicates.
- Reset mid-flight: 3 operations in flight, rst_n=0 for one edge -> next cycle out_valid=0 and all outputs are 0; none of the 3 tags ever appear; a new operation issued after reset returns 5 cycles later (WIDTH=8).

Source files
------------

// File: rtl/prefix_pkg.sv
// Shared types and helpers for the pipelined parallel-prefix arithmetic blocks.
package prefix_pkg;

   // Generate/propagate pair for one bit position or one prefix group.
   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   // Carry-in folded into bit 0; a subtract computes a + ~b + 1.
   localparam logic CARRY_IN = 1'b1;

   // Number of prefix levels needed to span a word of the given width.
   function automatic int unsigned prefix_levels(input int unsigned width);
      return $clog2(width);
   endfunction

   // Combine a high group with the adjacent lower group.
   function automatic pg_t blackcell(input pg_t hi, input pg_t lo);
      pg_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/sklansky_pipe_level.sv
// One Sklansky prefix level followed by its pipeline register.
// Sideband bits travel unchanged alongside the prefix vector.
module sklansky_pipe_level
   import prefix_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LEVEL = 1,
   parameter int unsigned SB_W  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   input  pg_t  [WIDTH-1:0]     in_pg,
   input  logic [SB_W-1:0]      in_sb,
   output logic                 out_valid,
   output pg_t  [WIDTH-1:0]     out_pg,
   output logic [SB_W-1:0]      out_sb
);

   localparam int unsigned HALF = 1 << (LEVEL - 1);

   pg_t [WIDTH-1:0] nxt_pg;

   // Upper half of each 2^LEVEL block merges with the top bit of its lower half.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int unsigned LO = ((i >> LEVEL) << LEVEL) + HALF - 1;
      if ((i % (2 * HALF)) >= HALF) begin : g_black
         assign nxt_pg[i] = blackcell(in_pg[i], in_pg[LO]);
      end else begin : g_pass
         assign nxt_pg[i] = in_pg[i];
      end
   end

   // Stage register; holds everything while the pipe is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pg    <= '0;
         out_sb    <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_pg    <= nxt_pg;
         out_sb    <= in_sb;
      end
   end

endmodule

// File: rtl/sklansky_pipe_subtractor.sv
// Pipelined a - b using a Sklansky borrow network, one register per prefix level.
// A single global enable stalls every stage together when the output is blocked.
module sklansky_pipe_subtractor
   import prefix_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  diff,
   output logic              borrow,
   output logic              overflow,
   output logic              zero,
   output logic              lt_s,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int unsigned N    = prefix_levels(WIDTH);
   // Sideband layout: {original p, tag, a_msb, b_msb}
   localparam int unsigned SB_W = WIDTH + TAG_W + 2;

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // S0: bitwise generate/propagate against ~b, carry-in folded into bit 0.
   logic [WIDTH-1:0] p_raw;
   logic [WIDTH-1:0] g_raw;
   pg_t  [WIDTH-1:0] pg0;

   assign p_raw = a ^ ~b;
   assign g_raw = a & ~b;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pg
      if (i == 0) begin : g_fold
         assign pg0[i] = pg_t'{g: g_raw[0] | (p_raw[0] & CARRY_IN), p: 1'b0};
      end else begin : g_plain
         assign pg0[i] = pg_t'{g: g_raw[i], p: p_raw[i]};
      end
   end

   logic             s0_valid;
   pg_t  [WIDTH-1:0] s0_pg;
   logic [SB_W-1:0]  s0_sb;

   // S0 register: accepts an operand pair or inserts a bubble when enabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_pg    <= '0;
         s0_sb    <= '0;
      end else if (en) begin
         s0_valid <= in_valid;
         s0_pg    <= pg0;
         s0_sb    <= {p_raw, in_tag, a[WIDTH-1], b[WIDTH-1]};
      end
   end

   // Prefix chain: element k is the output of level k, element 0 is S0.
   logic             lv_valid [N+1];
   pg_t  [WIDTH-1:0] lv_pg    [N+1];
   logic [SB_W-1:0]  lv_sb    [N+1];

   assign lv_valid[0] = s0_valid;
   assign lv_pg[0]    = s0_pg;
   assign lv_sb[0]    = s0_sb;

   for (genvar k = 1; k <= N; k++) begin : g_lvl
      sklansky_pipe_level #(
         .WIDTH (WIDTH),
         .LEVEL (k),
         .SB_W  (SB_W)
      ) u_level (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en),
         .in_valid  (lv_valid[k-1]),
         .in_pg     (lv_pg[k-1]),
         .in_sb     (lv_sb[k-1]),
         .out_valid (lv_valid[k]),
         .out_pg    (lv_pg[k]),
         .out_sb    (lv_sb[k])
      );
   end

   // SN+1: carries into each bit, difference and flags.
   logic [WIDTH-1:0] g_vec;
   logic [WIDTH-1:0] p_vec;
   logic [WIDTH-1:0] p_orig;
   logic [TAG_W-1:0] tag_n;
   logic             a_msb;
   logic             b_msb;
   logic [WIDTH-1:0] diff_c;
   logic             borrow_c;
   logic             ovf_c;
   logic             unused_group_p;

   for (genvar i = 0; i < WIDTH; i++) begin : g_unpack
      assign g_vec[i] = lv_pg[N][i].g;
      assign p_vec[i] = lv_pg[N][i].p;
   end

   // Group propagates of the last level are not needed once carries are known.
   assign unused_group_p = ^p_vec;

   assign p_orig   = lv_sb[N][SB_W-1 -: WIDTH];
   assign tag_n    = lv_sb[N][TAG_W+1:2];
   assign a_msb    = lv_sb[N][1];
   assign b_msb    = lv_sb[N][0];

   assign diff_c   = p_orig ^ {g_vec[WIDTH-2:0], CARRY_IN};
   assign borrow_c = ~g_vec[WIDTH-1];
   assign ovf_c    = (a_msb != b_msb) && (diff_c[WIDTH-1] != a_msb);

   // Output register; stable while the consumer holds off.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         lt_s      <= 1'b0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= lv_valid[N];
         diff      <= diff_c;
         borrow    <= borrow_c;
         overflow  <= ovf_c;
         zero      <= ~|diff_c;
         lt_s      <= diff_c[WIDTH-1] ^ ovf_c;
         out_tag   <= tag_n;
      end
   end

endmodule

// File: tb/tb_sklansky_pipe_subtractor.sv
// Scoreboard bench for the pipelined Sklansky subtractor at WIDTH=8 and WIDTH=32.
module tb_sklansky_pipe_subtractor;

   logic clk;
   int   tests;
   int   fails;

   // WIDTH=8 instance signals
   logic       rst_n8, v8, rdy8, ov8, ordy8, bo8, of8, z8, lt8;
   logic [7:0] a8, b8, d8;
   logic [3:0] tag8, otag8;

   // WIDTH=32 instance signals
   logic        rst_n32, v32, rdy32, ov32, ordy32, bo32, of32, z32, lt32;
   logic [31:0] a32, b32, d32;
   logic [3:0]  tag32, otag32;

   // Expected packing: {diff, borrow, overflow, zero, lt_s, tag}
   logic [15:0] q8 [$];
   logic [39:0] q32 [$];

   sklansky_pipe_subtractor #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n8), .in_valid(v8), .in_ready(rdy8),
      .a(a8), .b(b8), .in_tag(tag8), .out_valid(ov8), .out_ready(ordy8),
      .diff(d8), .borrow(bo8), .overflow(of8), .zero(z8), .lt_s(lt8),
      .out_tag(otag8)
   );

   sklansky_pipe_subtractor #(.WIDTH(32), .TAG_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n32), .in_valid(v32), .in_ready(rdy32),
      .a(a32), .b(b32), .in_tag(tag32), .out_valid(ov32), .out_ready(ordy32),
      .diff(d32), .borrow(bo32), .overflow(of32), .zero(z32), .lt_s(lt32),
      .out_tag(otag32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic [3:0] t);
      logic [8:0] fs;
      logic [7:0] d;
      fs = {x[7], x} - {y[7], y};
      d  = x - y;
      return {d, (x < y), (fs[8] != fs[7]), (d == 8'h00), ($signed(x) < $signed(y)), t};
   endfunction

   function automatic logic [39:0] model32(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] t);
      logic [32:0] fs;
      logic [31:0] d;
      fs = {x[31], x} - {y[31], y};
      d  = x - y;
      return {d, (x < y), (fs[32] != fs[31]), (d == 32'h0), ($signed(x) < $signed(y)), t};
   endfunction

   task automatic test_reset;
      v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; tag8 = 4'hF; ordy8 = 1'b1;
      v32 = 1'b1; a32 = 32'hDEADBEEF; b32 = 32'h1; tag32 = 4'hF; ordy32 = 1'b1;
      rst_n8 = 1'b0; rst_n32 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      v8 = 1'b0; v32 = 1'b0;
      #1;
      tests++;
      if ({ov8, d8, bo8, of8, z8, lt8, otag8} !== 17'h0) begin
         fails++;
         $display("FAIL reset8_outputs: got %h expected 0", {ov8, d8, bo8, of8, z8, lt8, otag8});
      end
      tests++;
      if ({ov32, d32, bo32, of32, z32, lt32, otag32} !== 41'h0) begin
         fails++;
         $display("FAIL reset32_outputs: got %h expected 0", {ov32, d32, bo32, of32, z32, lt32, otag32});
      end
      tests++;
      if ({rdy8, rdy32} !== 2'b11) begin
         fails++;
         $display("FAIL reset_in_ready: got %b expected 11", {rdy8, rdy32});
      end
      rst_n8 = 1'b1; rst_n32 = 1'b1;
   endtask

   task automatic test_latency;
      int it = 0;
      int acc_it = -1;
      int out_it = -1;
      logic [15:0] obs;
      while (out_it < 0 && it < 40) begin
         @(negedge clk);
         if (acc_it < 0) begin
            v8 = 1'b1; a8 = 8'h05; b8 = 8'h03; tag8 = 4'h1;
         end else begin
            v8 = 1'b0;
         end
         #1;
         if (ov8) begin
            out_it = it;
            obs = {d8, bo8, of8, z8, lt8, otag8};
            tests++;
            if (obs !== {8'h02, 4'b0000, 4'h1}) begin
               fails++;
               $display("FAIL latency_result: got %h expected %h", obs, {8'h02, 4'b0000, 4'h1});
            end
         end
         if (v8 && rdy8) acc_it = it;
         it++;
      end
      tests++;
      if (out_it - acc_it !== 5 || out_it < 0) begin
         fails++;
         $display("FAIL latency8: got %0d cycles expected 5", out_it - acc_it);
      end
   endtask

   task automatic test_directed;
      logic [7:0]  va [5];
      logic [7:0]  vb [5];
      logic [15:0] ve [5];
      logic [15:0] obs, exp;
      int sent = 0;
      int got = 0;
      int it = 0;
      va[0] = 8'h03; vb[0] = 8'h05; ve[0] = {8'hFE, 4'b1001, 4'h2};
      va[1] = 8'h80; vb[1] = 8'h01; ve[1] = {8'h7F, 4'b0101, 4'h3};
      va[2] = 8'h5A; vb[2] = 8'h5A; ve[2] = {8'h00, 4'b0010, 4'h4};
      va[3] = 8'h7F; vb[3] = 8'hFF; ve[3] = {8'h80, 4'b1100, 4'h5};
      va[4] = 8'hFF; vb[4] = 8'h00; ve[4] = {8'hFF, 4'b0001, 4'h6};
      while (got < 5 && it < 100) begin
         @(negedge clk);
         ordy8 = 1'b1;
         if (sent < 5) begin
            v8 = 1'b1; a8 = va[sent]; b8 = vb[sent]; tag8 = ve[sent][3:0];
         end else begin
            v8 = 1'b0;
         end
         #1;
         if (ov8 && ordy8) begin
            obs = {d8, bo8, of8, z8, lt8, otag8};
            exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            tests++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL directed_result: got %h expected %h", obs, exp);
            end
            got++;
         end
         if (v8 && rdy8) begin
            q8.push_back(ve[sent]);
            sent++;
         end
         it++;
      end
      tests++;
      if (got !== 5) begin
         fails++;
         $display("FAIL directed_count: got %0d results expected 5", got);
      end
   endtask

   task automatic test_backpressure;
      logic [7:0]  pa [10];
      logic [7:0]  pb [10];
      logic [15:0] obs, exp;
      int sent = 0;
      int got = 0;
      int it = 0;
      int stalled = 0;
      int extra = 0;
      for (int i = 0; i < 10; i++) begin
         pa[i] = 8'($urandom_range(0, 255));
         pb[i] = 8'($urandom_range(0, 255));
      end
      while (got < 10 && it < 200) begin
         @(negedge clk);
         ordy8 = !(ov8 && got >= 2 && stalled < 3);
         if (!ordy8) stalled++;
         if (sent < 10) begin
            v8 = 1'b1; a8 = pa[sent]; b8 = pb[sent]; tag8 = sent[3:0];
         end else begin
            v8 = 1'b0;
         end
         #1;
         if (!ordy8) begin
            tests++;
            if (rdy8 !== 1'b0 || ov8 !== 1'b1) begin
               fails++;
               $display("FAIL bp_stall: got in_ready=%b out_valid=%b expected 0/1", rdy8, ov8);
            end
         end
         if (ov8 && ordy8) begin
            obs = {d8, bo8, of8, z8, lt8, otag8};
            exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
            tests++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL bp_result: got %h expected %h", obs, exp);
            end
            got++;
         end
         if (v8 && rdy8) begin
            q8.push_back(model8(pa[sent], pb[sent], sent[3:0]));
            sent++;
         end
         it++;
      end
      ordy8 = 1'b1;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (ov8) extra++;
      end
      tests++;
      if (got !== 10 || extra !== 0) begin
         fails++;
         $display("FAIL bp_count: got %0d results plus %0d extra expected 10 plus 0", got, extra);
      end
   endtask

   task automatic test_reset_flight;
      int n = 0;
      int it = 0;
      int acc_it = -1;
      int seen = 0;
      logic [15:0] obs;
      ordy8 = 1'b1;
      while (n < 3 && it < 20) begin
         @(negedge clk);
         v8 = 1'b1; a8 = 8'h20 + 8'(n); b8 = 8'h01; tag8 = 4'hA + 4'(n);
         #1;
         if (v8 && rdy8) n++;
         it++;
      end
      @(negedge clk);
      v8 = 1'b0;
      rst_n8 = 1'b0;
      @(negedge clk);
      rst_n8 = 1'b1;
      #1;
      tests++;
      if ({ov8, d8, bo8, of8, z8, lt8, otag8} !== 17'h0) begin
         fails++;
         $display("FAIL flush_outputs: got %h expected 0", {ov8, d8, bo8, of8, z8, lt8, otag8});
      end
      q8.delete();
      for (it = 0; it < 20; it++) begin
         @(negedge clk);
         if (acc_it < 0) begin
            v8 = 1'b1; a8 = 8'h10; b8 = 8'h01; tag8 = 4'h3;
         end else begin
            v8 = 1'b0;
         end
         #1;
         if (ov8) begin
            seen++;
            obs = {d8, bo8, of8, z8, lt8, otag8};
            tests++;
            if (obs !== {8'h0F, 4'b0000, 4'h3} || it - acc_it !== 5) begin
               fails++;
               $display("FAIL flush_new_op: got %h after %0d cycles expected %h after 5",
                        obs, it - acc_it, {8'h0F, 4'b0000, 4'h3});
            end
         end
         if (v8 && rdy8 && acc_it < 0) acc_it = it;
      end
      tests++;
      if (seen !== 1) begin
         fails++;
         $display("FAIL flush_count: got %0d results expected 1", seen);
      end
   endtask

   task automatic test_back_to_back;
      logic [39:0] obs, exp;
      int sent = 0;
      int got = 0;
      int it = 0;
      int gaps = 0;
      int first_acc = -1;
      int first_out = -1;
      ordy32 = 1'b1;
      while (got < 1000 && it < 3000) begin
         @(negedge clk);
         if (sent < 1000) begin
            v32 = 1'b1;
            a32 = $urandom;
            b32 = (sent % 64 == 0) ? a32 : $urandom;
            tag32 = sent[3:0];
         end else begin
            v32 = 1'b0;
         end
         #1;
         if (ov32) begin
            if (first_out < 0) first_out = it;
            obs = {d32, bo32, of32, z32, lt32, otag32};
            exp = (q32.size() > 0) ? q32.pop_front() : 40'hx;
            tests++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL b2b_result: got %h expected %h", obs, exp);
            end
            got++;
         end else if (first_out >= 0 && got < 1000) begin
            gaps++;
         end
         if (v32 && rdy32) begin
            if (first_acc < 0) first_acc = it;
            q32.push_back(model32(a32, b32, tag32));
            sent++;
         end
         it++;
      end
      v32 = 1'b0;
      tests++;
      if (first_out - first_acc !== 7 || first_out < 0) begin
         fails++;
         $display("FAIL latency32: got %0d cycles expected 7", first_out - first_acc);
      end
      tests++;
      if (gaps !== 0 || got !== 1000) begin
         fails++;
         $display("FAIL b2b_throughput: got %0d results with %0d gaps expected 1000 with 0", got, gaps);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_latency();
      test_directed();
      test_backpressure();
      test_reset_flight();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
